morse_key_capture: RTL and testbench

//  Upstream feeder of the LED code-display stage. Debounces one Morse key and

---
 rtl/morse_key_capture_if.sv | 26 ++
 rtl/morse_key_capture.sv | 167 ++++++++++++++++
 tb/tb_morse_key_capture.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/morse_key_capture_if.sv
`default_nettype none
// =============================================================================
//  Module   : morse_key_capture_if
//  Purpose  : Key input and committed letter output bundle of the Morse capture.
//  Revision : 1.0  initial release
// =============================================================================
interface morse_key_capture_if;
    logic       key_raw;
    logic       clear;
    logic [4:0] code;
    logic [2:0] width;
    logic       done;
    logic       busy;
    logic       key_db;

    modport master (
        output key_raw, clear,
        input  code, width, done, busy, key_db
    );

    modport slave (
        input  key_raw, clear,
        output code, width, done, busy, key_db
    );
endinterface
`default_nettype wire

// File: rtl/morse_key_capture.sv
`default_nettype none
// =============================================================================
//  Module   : morse_key_capture
//  Purpose  : Debounces a Morse key, times presses into dots/dashes and commits
//             up to five symbols per letter after an idle gap.
//  Revision : 1.0  initial release
// =============================================================================
module morse_key_capture #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DASH_CYCLES     = 12500000,
    parameter int GAP_CYCLES      = 25000000,
    parameter int CNT_W           = 26
) (
    input  logic                clk,
    input  logic                rst,
    morse_key_capture_if.slave  bus
);

    localparam int               DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_T   = CNT_W'(DASH_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    logic             r_sync1, r_sync2, r_sync_d;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_key_db, r_key_db_d;
    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_timer, w_timer_n;
    logic [4:0]       r_wcode, w_wcode_n;
    logic [2:0]       r_wcnt, w_wcnt_n;
    logic [4:0]       r_code, w_code_n;
    logic [2:0]       r_width, w_width_n;
    logic             r_done, w_done_n;
    logic             r_busy;
    logic             w_rise, w_fall, w_sym;
    logic [4:0]       w_shifted;

    // Debounce: the counter tracks consecutive cycles of an unchanged sync level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync_d   <= 1'b0;
            r_db_cnt   <= '0;
            r_key_db   <= 1'b0;
            r_key_db_d <= 1'b0;
        end else begin
            r_sync1    <= bus.key_raw;
            r_sync2    <= r_sync1;
            r_sync_d   <= r_sync2;
            r_key_db_d <= r_key_db;
            if (r_sync2 != r_sync_d) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt != DB_LAST) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end else begin
                r_key_db <= r_sync2;
            end
        end
    end

    assign w_rise    = r_key_db & ~r_key_db_d;
    assign w_fall    = ~r_key_db & r_key_db_d;
    assign w_sym     = (r_timer >= DASH_T);
    assign w_shifted = {r_wcode[3:0], w_sym};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_wcode <= '0;
            r_wcnt  <= '0;
            r_code  <= '0;
            r_width <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_timer <= w_timer_n;
            r_wcode <= w_wcode_n;
            r_wcnt  <= w_wcnt_n;
            r_code  <= w_code_n;
            r_width <= w_width_n;
            r_done  <= w_done_n;
            r_busy  <= (w_state_n != IDLE);
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_timer_n = (&r_timer) ? r_timer : r_timer + 1'b1;
        w_wcode_n = r_wcode;
        w_wcnt_n  = r_wcnt;
        w_code_n  = r_code;
        w_width_n = r_width;
        w_done_n  = 1'b0;

        if (bus.clear) begin
            w_state_n = IDLE;
            w_timer_n = '0;
            w_wcode_n = '0;
            w_wcnt_n  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_timer_n = '0;
                    if (w_rise) begin
                        w_state_n = PRESS;
                        w_wcode_n = '0;
                        w_wcnt_n  = '0;
                    end
                end
                PRESS: begin
                    if (w_fall) begin
                        w_timer_n = '0;
                        w_wcode_n = w_shifted;
                        w_wcnt_n  = r_wcnt + 1'b1;
                        // Fifth symbol fills the letter, so it commits without a gap.
                        if (r_wcnt == 3'd4) begin
                            w_state_n = IDLE;
                            w_code_n  = w_shifted;
                            w_width_n = 3'd5;
                            w_done_n  = 1'b1;
                            w_wcode_n = '0;
                            w_wcnt_n  = '0;
                        end else begin
                            w_state_n = GAP;
                        end
                    end
                end
                GAP: begin
                    // Commit outranks a rise landing on the last gap cycle.
                    if (r_timer == GAP_LAST) begin
                        w_state_n = IDLE;
                        w_timer_n = '0;
                        w_code_n  = r_wcode;
                        w_width_n = r_wcnt;
                        w_done_n  = 1'b1;
                        w_wcode_n = '0;
                        w_wcnt_n  = '0;
                    end else if (w_rise) begin
                        w_state_n = PRESS;
                        w_timer_n = '0;
                    end
                end
                default: begin
                    w_state_n = IDLE;
                    w_timer_n = '0;
                end
            endcase
        end
    end

    assign bus.code   = r_code;
    assign bus.width  = r_width;
    assign bus.done   = r_done;
    assign bus.busy   = r_busy;
    assign bus.key_db = r_key_db;

endmodule
`default_nettype wire

// File: tb/tb_morse_key_capture.sv
`default_nettype none
// =============================================================================
//  Module   : tb_morse_key_capture
//  Purpose  : Directed-vector bench with a commit scoreboard for morse_key_capture.
//  Revision : 1.0  initial release
// =============================================================================
module tb_morse_key_capture;

    logic clk = 1'b0;
    logic rst = 1'b1;

    morse_key_capture_if bus ();

    morse_key_capture #(
        .DEBOUNCE_CYCLES (4),
        .DASH_CYCLES     (20),
        .GAP_CYCLES      (50),
        .CNT_W           (26)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    int         done_cnt = 0;
    logic       done_prev = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected {code,width} pair.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("commit_code", int'(bus.code), int'(e[7:3]));
                    check("commit_width", int'(bus.width), int'(e[2:0]));
                end
            end
            if (bus.done && done_prev) check("done_one_cycle", 2, 1);
            if (bus.width > 3'd5) check("width_max5", int'(bus.width), 5);
            if ((bus.code >> bus.width) != 5'd0) check("code_upper_zero", int'(bus.code), 0);
            done_prev = bus.done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic hold(input logic v, input int n);
        bus.key_raw = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_letter(input logic [4:0] c, input logic [2:0] w);
        exp_q.push_back({c, w});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   start;
        logic seen_high;
        bus.key_raw = 1'b0;
        bus.clear   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_code", int'(bus.code), 0);
        check("reset_width", int'(bus.width), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_key_db", int'(bus.key_db), 0);
        rst = 1'b0;
        hold(0, 5);

        // Single dot.
        expect_letter(5'b00000, 3'd1);
        hold(1, 10);
        hold(0, 80);

        // Dash, dot, dash.
        expect_letter(5'b00101, 3'd3);
        hold(1, 30); hold(0, 10);
        hold(1, 10); hold(0, 10);
        hold(1, 30); hold(0, 80);

        // Bouncing key never settles long enough.
        seen_high = 1'b0;
        for (int i = 0; i < 10; i++) begin
            hold(1, 2);
            seen_high |= bus.key_db | bus.busy;
            hold(0, 2);
            seen_high |= bus.key_db | bus.busy;
        end
        hold(0, 20);
        check("bounce_no_key_db", int'(seen_high), 0);
        check("bounce_busy", int'(bus.busy), 0);

        // Five dashes commit on the fifth release without a gap wait.
        expect_letter(5'b11111, 3'd5);
        start = done_cnt;
        for (int i = 0; i < 5; i++) begin
            hold(1, 30);
            if (i < 4) hold(0, 10);
        end
        hold(0, 12);
        check("five_no_gap_wait", done_cnt, start + 1);
        expect_letter(5'b00000, 3'd1);
        hold(1, 10);
        hold(0, 80);

        // Clear in the gap after two dots.
        start = done_cnt;
        hold(1, 10); hold(0, 10);
        hold(1, 10); hold(0, 25);
        check("clear_busy_before", int'(bus.busy), 1);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        check("clear_busy_after", int'(bus.busy), 0);
        hold(0, 80);
        check("clear_no_done", done_cnt, start);
        check("clear_code_kept", int'(bus.code), 0);
        check("clear_width_kept", int'(bus.width), 1);

        // Reset during the second press of a letter.
        expect_letter(5'b00001, 3'd1);
        hold(1, 30);
        hold(0, 80);
        hold(1, 10); hold(0, 10); hold(1, 15);
        check("rst_busy_before", int'(bus.busy), 1);
        rst = 1'b1;
        bus.key_raw = 1'b0;
        @(posedge clk);
        #1;
        check("rst_code", int'(bus.code), 0);
        check("rst_width", int'(bus.width), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        rst = 1'b0;
        hold(0, 20);

        // Recovery after reset.
        expect_letter(5'b00001, 3'd1);
        hold(1, 30);
        hold(0, 80);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
